pipelined_adder: RTL and testbench

- Parametrised, pipelined successor to the team's 1-bit full-adder cell: a WIDTH-bit add/subtract unit built as a chain of SEG-bit ripple segments with registered carries between segments.
- Used wherever wide score, timer or position arithmetic must close timing at the board clock.
- Operands enter with a valid/ready handshake. Results leave STAGES cycles later with carry-out and signed-overflow flags.

---
 rtl/pipelined_adder_if.sv | 27 ++
 rtl/pipelined_adder.sv | 124 ++++++++++++
 tb/tb_pipelined_adder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The master side supplies operands and consumes results.
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract built from SEG-bit ripple segments with registered carries.
// Optional: define PIPELINED_ADDER_SAT_EN to saturate the final sum on signed overflow.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_adder_if.slave  bus
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  // Whole pipeline moves as one; a stalled result freezes every stage.
  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SEG;
    localparam int REM = WIDTH - LO;

    // w carries {unsummed A bits above LO, finished sum bits below LO}.
    logic [WIDTH-1:0] w_in;
    logic [REM-1:0]   bp_in;
    logic             c_in;
    logic             v_in;

    logic [WIDTH-1:0] w_q;
    logic             c_q;
    logic             v_q;

    if (k == 0) begin : g_src
      assign w_in  = bus.a;
      assign bp_in = bus.sub ? ~bus.b : bus.b;
      assign c_in  = bus.sub | bus.cin;
      assign v_in  = bus.in_valid;
    end else begin : g_src
      assign w_in  = g_stage[k-1].w_q;
      assign bp_in = g_stage[k-1].g_fwd.bp_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
    end

    logic [SEG-1:0] a_s;
    logic [SEG-1:0] b_s;
    logic [SEG:0]   slice;
    logic [WIDTH-1:0] w_next;

    assign a_s   = w_in[LO +: SEG];
    assign b_s   = bp_in[SEG-1:0];
    assign slice = {1'b0, a_s} + {1'b0, b_s} + {{SEG{1'b0}}, c_in};

    // NOTE: every variable assigned in always_comb gets a full default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
      w_next           = w_in;
      w_next[LO +: SEG] = slice[SEG-1:0];
    end

    if (k == LAST) begin : g_last
      logic             msb_cin;
      logic             ovf_n;
      logic [WIDTH-1:0] sum_n;
      logic             ovf_q;

      // Carry into the MSB recovered from the sum bit: s = a ^ b ^ cin.
      assign msb_cin = a_s[SEG-1] ^ b_s[SEG-1] ^ slice[SEG-1];
      assign ovf_n   = msb_cin ^ slice[SEG];

`ifdef PIPELINED_ADDER_SAT_EN
      // On overflow both operand MSBs agree and give the sign of the true result.
      always_comb begin
        sum_n = w_next;
        if (ovf_n) begin
          sum_n = a_s[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end
`else
      assign sum_n = w_next;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          w_q   <= '0;
          c_q   <= 1'b0;
          v_q   <= 1'b0;
          ovf_q <= 1'b0;
        end else if (adv) begin
          w_q   <= sum_n;
          c_q   <= slice[SEG];
          v_q   <= v_in;
          ovf_q <= ovf_n;
        end
      end
    end else begin : g_fwd
      logic [REM-SEG-1:0] bp_q;

      // NOTE: state registers use non-blocking assignments so every stage
      // samples its neighbour's pre-edge value and the shift is order-free.
      always_ff @(posedge clk) begin
        if (rst) begin
          w_q  <= '0;
          bp_q <= '0;
          c_q  <= 1'b0;
          v_q  <= 1'b0;
        end else if (adv) begin
          w_q  <= w_next;
          bp_q <= bp_in[REM-1:SEG];
          c_q  <= slice[SEG];
          v_q  <= v_in;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[LAST].v_q;
  assign bus.sum       = g_stage[LAST].w_q;
  assign bus.cout      = g_stage[LAST].c_q;
  assign bus.ovf       = g_stage[LAST].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=16, SEG=4, latency 4).
// Expected values follow PIPELINED_ADDER_SAT_EN when the bench is built with it.
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(16)) bus ();

  pipelined_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One operation into an idle pipeline; checks latency and all result fields.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tcin, input logic tsub,
                        input logic [15:0] es, input logic ec, input logic eo,
                        input string name);
    int lat;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = ta;
    bus.b         = tb_v;
    bus.cin       = tcin;
    bus.sub       = tsub;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles expected 4", name, lat);
    end
    checks++;
    if (bus.sum !== es) begin
      errors++;
      $display("FAIL %s sum: got %h expected %h", name, bus.sum, es);
    end
    checks++;
    if (bus.cout !== ec) begin
      errors++;
      $display("FAIL %s cout: got %b expected %b", name, bus.cout, ec);
    end
    checks++;
    if (bus.ovf !== eo) begin
      errors++;
      $display("FAIL %s ovf: got %b expected %b", name, bus.ovf, eo);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: got valid=%b sum=%h cout=%b ovf=%b ready=%b expected 0 0000 0 0 1",
               bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.in_ready);
    end
  endtask

  task automatic test_latency_carry();
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "ripple_00ff");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap_ffff");
    run_op(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0, "cin_add");
  endtask

  task automatic test_sub_ovf();
    run_op(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    run_op(16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_cin_ignored");
`ifdef PIPELINED_ADDER_SAT_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, "pos_ovf");
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1, "neg_ovf");
`else
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");
`endif
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [8] = '{16'h0001, 16'h00FF, 16'h0F0F, 16'h1234,
                            16'hFFFF, 16'h1000, 16'hABCD, 16'h0005};
    logic [15:0] vb [8] = '{16'h0002, 16'h0001, 16'h00F1, 16'h4321,
                            16'h0002, 16'h0001, 16'h1111, 16'h0007};
    logic        vs [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] ve [8] = '{16'h0003, 16'h0100, 16'h1000, 16'h5555,
                            16'h0001, 16'h0FFF, 16'hBCDE, 16'hFFFE};
    int          idx_in = 0;
    int          idx_out = 0;
    int          cyc = 0;
    logic        stall;
    logic        held = 1'b0;
    logic [15:0] held_sum = '0;
    while (idx_out < 8 && cyc < 100) begin
      @(negedge clk);
      stall         = (cyc >= 5 && cyc < 8);
      bus.out_ready = !stall;
      bus.in_valid  = (idx_in < 8);
      bus.a         = va[idx_in % 8];
      bus.b         = vb[idx_in % 8];
      bus.sub       = vs[idx_in % 8];
      bus.cin       = 1'b0;
      #1;
      if (stall && bus.out_valid) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b stall in_ready: got %b expected 0 at cycle %0d", bus.in_ready, cyc);
        end
        if (held) begin
          checks++;
          if (bus.sum !== held_sum) begin
            errors++;
            $display("FAIL b2b stall hold: got %h expected %h", bus.sum, held_sum);
          end
        end
        held     = 1'b1;
        held_sum = bus.sum;
      end
      if (bus.in_valid && bus.in_ready) idx_in++;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.sum !== ve[idx_out]) begin
          errors++;
          $display("FAIL b2b result %0d: got %h expected %h", idx_out, bus.sum, ve[idx_out]);
        end
        idx_out++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (idx_out !== 8 || !held) begin
      errors++;
      $display("FAIL b2b count: got %0d results (stall seen %b) expected 8", idx_out, held);
    end
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b extra result: got out_valid=%b sum=%h expected 0", bus.out_valid, bus.sum);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int spurious = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h1111;
    bus.b         = 16'h2222;
    bus.sub       = 1'b0;
    bus.cin       = 1'b0;
    @(negedge clk);
    bus.a = 16'h3333;
    bus.b = 16'h4444;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== {1'b0, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset values: got valid=%b sum=%h cout=%b ovf=%b expected 0 0000 0 0",
               bus.out_valid, bus.sum, bus.cout, bus.ovf);
    end
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      errors++;
      $display("FAIL midreset discard: got %0d valid cycles expected 0", spurious);
    end
    run_op(16'h0F00, 16'h00F0, 1'b1, 1'b0, 16'h0FF1, 1'b0, 1'b0, "after_reset");
  endtask

`ifdef PIPELINED_ADDER_SAT_EN
  task automatic test_saturation();
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, "sat_pos");
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, "sat_neg");
    run_op(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, "sat_none");
  endtask
`else
  task automatic test_wrap();
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "wrap_sub_ovf");
    run_op(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, "plain_add");
  endtask
`endif

  initial begin
    test_reset();
    test_latency_carry();
    test_sub_ovf();
    test_back_to_back();
    test_reset_midflight();
`ifdef PIPELINED_ADDER_SAT_EN
    test_saturation();
`else
    test_wrap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
